// File: rtl/mipi_dphy_lane_rx.sv
// mipi_dphy_lane_rx: receive controller for one MIPI D-PHY data lane.
// Filters the LP line levels, follows the LP-11 -> LP-01 -> LP-00 start of
// transmission, enables HS termination, finds the 0xB8 sync byte at any bit
// offset and delivers aligned payload bytes until the lane returns to LP-11.
// Optional escape-entry detection is built when MIPI_RX_ESC_DETECT_EN is defined.
// Ports:
//   i_clk         byte clock
//   i_rst         asynchronous active-high reset
//   i_lp          raw LP levels {Dp,Dn}, asynchronous
//   i_hs_byte     unaligned deserialized HS byte, LSB first on the wire
//   o_hs_term_en  HS receiver/termination enable
//   o_byte        aligned payload byte
//   o_byte_valid  o_byte holds a payload byte
//   o_sot         pulse with the first payload byte
//   o_eot         pulse on return to LP-11 from HS_DATA
//   o_sync_err    pulse on sync-search timeout
//   o_esc         pulse on escape-mode entry
//   o_in_esc      lane is in escape mode
//   o_state       current state encoding
module mipi_dphy_lane_rx #(
   parameter int LP_FILT    = 4,
   parameter int SETTLE_CYC = 6,
   parameter int SYNC_TO    = 64
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] i_lp,
   input  logic [7:0] i_hs_byte,
   output logic       o_hs_term_en,
   output logic [7:0] o_byte,
   output logic       o_byte_valid,
   output logic       o_sot,
   output logic       o_eot,
   output logic       o_sync_err,
   output logic       o_esc,
   output logic       o_in_esc,
   output logic [2:0] o_state
);
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      HS_RQST  = 3'd1,
      HS_PREP  = 3'd2,
      HS_SYNC  = 3'd3,
      HS_DATA  = 3'd4,
      ERR_WAIT = 3'd5,
      ESC_RQST = 3'd6,
      ESC_WAIT = 3'd7
   } state_t;

   localparam int FW   = $clog2(LP_FILT + 1);
   localparam int CMAX = SETTLE_CYC > SYNC_TO ? SETTLE_CYC : SYNC_TO;
   localparam int CW   = $clog2(CMAX + 1);

   state_t        state, nxt;
   logic [1:0]    lp_s1, lp_s2, lp_cand, lp_f;
   logic [FW-1:0] filt_cnt, filt_nxt;
   logic [CW-1:0] cnt;
   logic [7:0]    prev;
   logic [15:0]   w;
   logic [2:0]    k, k_hit;
   logic          hit, in_data;

   assign w            = {i_hs_byte, prev};
   assign in_data      = state == HS_DATA && nxt == HS_DATA;
   assign o_hs_term_en = state == HS_PREP || state == HS_SYNC || state == HS_DATA;
   assign o_state      = state;

   // Run length of the current synchronized value, saturating at LP_FILT.
   assign filt_nxt = (lp_s2 != lp_cand) ? FW'(1) :
                     (filt_cnt < FW'(LP_FILT)) ? filt_cnt + 1'b1 : filt_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         lp_s1    <= 2'b11;
         lp_s2    <= 2'b11;
         lp_cand  <= 2'b11;
         lp_f     <= 2'b11;
         filt_cnt <= '0;
      end else begin
         lp_s1    <= i_lp;
         lp_s2    <= lp_s1;
         lp_cand  <= lp_s2;
         filt_cnt <= filt_nxt;
         if (filt_nxt >= FW'(LP_FILT)) lp_f <= lp_s2;
      end
   end

   always_comb begin
      nxt   = state;
      hit   = 1'b0;
      k_hit = 3'd0;
      // Scanning downward leaves the lowest matching offset in k_hit.
      for (int i = 7; i >= 0; i--)
         if (w[i +: 8] == 8'hB8) begin
            hit   = 1'b1;
            k_hit = 3'(i);
         end
      if (state != IDLE && lp_f == 2'b11) nxt = IDLE;
      else
         case (state)
            IDLE: begin
               if (lp_f == 2'b01) nxt = HS_RQST;
`ifdef MIPI_RX_ESC_DETECT_EN
               else if (lp_f == 2'b10) nxt = ESC_RQST;
`endif
            end
            HS_RQST:  nxt = lp_f == 2'b00 ? HS_PREP : lp_f == 2'b10 ? ERR_WAIT : HS_RQST;
            HS_PREP:  nxt = lp_f != 2'b00 ? ERR_WAIT : cnt == CW'(SETTLE_CYC - 1) ? HS_SYNC : HS_PREP;
            HS_SYNC:  nxt = hit ? HS_DATA : cnt == CW'(SYNC_TO - 1) ? ERR_WAIT : HS_SYNC;
`ifdef MIPI_RX_ESC_DETECT_EN
            ESC_RQST: nxt = lp_f == 2'b00 ? ESC_WAIT : lp_f == 2'b01 ? ERR_WAIT : ESC_RQST;
`endif
            default:  nxt = state;
         endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= IDLE;
         cnt          <= '0;
         prev         <= 8'h00;
         k            <= 3'd0;
         o_byte       <= 8'h00;
         o_byte_valid <= 1'b0;
         o_sot        <= 1'b0;
         o_eot        <= 1'b0;
         o_sync_err   <= 1'b0;
      end else begin
         state        <= nxt;
         prev         <= i_hs_byte;
         // Every state change restarts the settle/timeout counter.
         cnt          <= (nxt != state) ? '0 : (cnt < CW'(CMAX)) ? cnt + 1'b1 : cnt;
         if (state == HS_SYNC && nxt == HS_DATA) k <= k_hit;
         if (in_data) o_byte <= w[k +: 8];
         o_byte_valid <= in_data;
         o_sot        <= in_data && !o_byte_valid;
         o_eot        <= state == HS_DATA && nxt == IDLE;
         o_sync_err   <= state == HS_SYNC && nxt == ERR_WAIT;
      end
   end

`ifdef MIPI_RX_ESC_DETECT_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) o_esc <= 1'b0;
      else       o_esc <= state == ESC_RQST && nxt == ESC_WAIT;
   end
   assign o_in_esc = state == ESC_WAIT;
`else
   assign o_esc    = 1'b0;
   assign o_in_esc = 1'b0;
`endif
endmodule
